// File: rtl/mult_iter_unit_pkg.sv
// Shared definitions for the iterative multiplier and the pipeline
// control blocks that track its state.
package mult_iter_unit_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_iter_unit_if.sv
// Execute-stage request/response bundle for the iterative multiplier.
// master = execute control side, slave = multiplier.
interface mult_iter_unit_if
    import mult_iter_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);

    logic             mult_enable;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sfmux_high;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] sf_data;

    modport master (
        output mult_enable,
        output a,
        output b,
        output sfmux_high,
        input  stall,
        input  done,
        input  hi,
        input  lo,
        input  sf_data
    );

    modport slave (
        input  mult_enable,
        input  a,
        input  b,
        input  sfmux_high,
        output stall,
        output done,
        output hi,
        output lo,
        output sf_data
    );

endinterface

// File: rtl/mult_iter_unit.sv
// Unsigned shift-add multiplier, one partial-product step per cycle.
// hi/lo only ever change to a finished product.
module mult_iter_unit
    import mult_iter_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    mult_iter_unit_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mult_state_e      state_q;
    mult_state_e      state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             start;
    logic             busy;
    logic             last;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] mplier_nx;

    assign busy  = (state_q == BUSY);
    assign start = bus.mult_enable &
                   ((state_q == IDLE) | (state_q == DONE));
    assign last  = busy & (cnt_q == LAST);

    // Sum keeps the carry; it shifts down into the accumulator MSB.
    always_comb begin
        sum       = {1'b0, acc_q};
        if (mplier_q[0]) begin
            sum = {1'b0, acc_q} + {1'b0, mcand_q};
        end
        acc_nx    = sum[WIDTH:1];
        mplier_nx = {sum[0], mplier_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? BUSY : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (start) begin
            cnt_q    <= '0;
            mcand_q  <= bus.a;
            mplier_q <= bus.b;
            acc_q    <= '0;
        end else if (busy) begin
            cnt_q    <= cnt_q + CW'(1);
            acc_q    <= acc_nx;
            mplier_q <= mplier_nx;
            if (last) begin
                hi_q <= acc_nx;
                lo_q <= mplier_nx;
            end
        end
    end

    assign bus.stall   = busy | start;
    assign bus.done    = (state_q == DONE);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.sf_data = bus.sfmux_high ? hi_q : lo_q;

endmodule

// File: doc/mult_iter_unit.md
MULT_ITER_UNIT -- requirements
Module: mult_iter_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mult_enable  input  1  start request from the execute-stage control signal.
REQ-005 SHALL have port a  input  WIDTH  multiplicand, sampled only on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  multiplier, sampled only on an accepted start.
REQ-007 SHALL have port sfmux_high  input  1  read select: 1 selects HI, 0 selects LO.
REQ-008 SHALL have port stall  output  1  pipeline stall request to hazard logic.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port hi  output  WIDTH  upper half of the last completed product.
REQ-011 SHALL have port lo  output  WIDTH  lower half of the last completed product.
REQ-012 SHALL have port sf_data  output  WIDTH  equal to sfmux_high ? hi : lo, purely combinational.

Function
REQ-013 SHALL implement an unsigned shift-add multiplier with a 3-state FSM: IDLE, BUSY, DONE.
REQ-014 SHALL accept a start when mult_enable=1 in IDLE or DONE: latch a and b, clear the accumulator, clear the counter, and enter BUSY at that edge.
REQ-015 SHALL ignore mult_enable while in BUSY: no operand latch and no restart.
REQ-016 SHALL perform one iteration per BUSY cycle:
- if multiplier LSB=1, add the multiplicand into the accumulator upper half, using a WIDTH+1-bit sum to keep the carry;
- shift the {carry, accumulator, multiplier} chain right by 1.
REQ-017 SHALL count iterations 0..WIDTH-1 and leave BUSY for DONE at the edge that completes iteration WIDTH-1.
REQ-018 SHALL load hi/lo from the final 2*WIDTH-bit product at the edge entering DONE, so the values are visible during the DONE cycle.
REQ-019 SHALL hold hi/lo unchanged at all other times, including throughout BUSY.
REQ-020 SHALL assert done only in the DONE cycle; with a start at edge E0, done is high in the cycle after edge E(WIDTH).
REQ-021 SHALL leave DONE for IDLE on the next edge when there is no start, or for BUSY on an accepted start (back-to-back operation).
REQ-022 SHALL drive stall = (state==BUSY) | (state==IDLE & mult_enable) | (state==DONE & mult_enable), combinationally.
REQ-023 SHALL produce an exact result for full-scale operands; the product never overflows 2*WIDTH bits.
REQ-024 SHALL NOT expose a partial product on hi/lo at any time.

Reset
REQ-025 SHALL, with rst=0, immediately force: state=IDLE, counter=0, accumulator=0, operand registers=0, hi=0, lo=0, done=0.
REQ-026 SHALL abort any in-flight operation on reset without a done pulse; the aborted result is discarded.
REQ-027 SHALL require mult_enable after reset release to start a new operation.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/BUSY/DONE) and the default WIDTH constant in the shared package used by the pipeline control blocks.
REQ-029 SHALL be a single module with no sub-module; adder, shifter and counter are inline.

Verification
REQ-030 SHALL verify: a=3, b=5, start at E0 -> stall high for cycles 0..32, done in cycle 33, hi=0x00000000, lo=0x0000000F.
REQ-031 SHALL verify: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; carry path exercised.
REQ-032 SHALL verify: second mult_enable at cycle 10 with new operands -> ignored; result is the first product, with exactly one done pulse.
REQ-033 SHALL verify: rst low at cycle 15 of BUSY -> immediate IDLE, hi=lo=0, stall=0, no done; a fresh 7*6 afterwards -> lo=42.
REQ-034 SHALL verify: start during the DONE cycle with a=2, b=9 -> first result visible in DONE, then BUSY again, then lo=18 after 32 more cycles.
REQ-035 SHALL verify: after 0x10000*0x10000 -> hi=1, lo=0; sfmux_high=1 gives sf_data=0x00000001, sfmux_high=0 gives sf_data=0x00000000.
